// File: rtl/odpc_pkg.sv
// Shared constants and helpers for the ODPC range-guard pipeline.
package odpc_pkg;

  localparam int CLAMP_BOUND = 0;
  localparam int CLAMP_ZERO  = 1;

  function automatic int code_w(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

  // Counts set bits of a vector of up to 32 channels.
  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/odpc_msb_diff_encoder.sv
// Encodes a difference vector as {found, index of most significant set bit}.
module odpc_msb_diff_encoder #(
  parameter int DATA_W = 8,
  parameter int CODE_W = $clog2(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] d_i,
  output logic [CODE_W-1:0] code_o
);

  localparam int IDX_W = CODE_W - 1;

  logic [IDX_W-1:0] idx;

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d_i[i]) idx = IDX_W'(i);
    end
  end

  assign code_o = {|d_i, idx};

endmodule

// File: rtl/odpc_range_guard_pipe.sv
// Two-stage multi-channel range guard with valid/ready flow control.
// Optional per-channel even-parity checking is enabled with ODPC_PARITY_EN.
module odpc_range_guard_pipe
  import odpc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int CODE_W     = code_w(DATA_W),
  parameter int CNT_W      = 16,
  parameter int CLAMP_MODE = CLAMP_BOUND
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0]        in_min,
  input  logic [DATA_W-1:0]        in_max,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_x,
  output logic [NUM_CH*CODE_W-1:0] out_code_max,
  output logic [NUM_CH*CODE_W-1:0] out_code_min,
  output logic [NUM_CH-1:0]        out_hi,
  output logic [NUM_CH-1:0]        out_lo,
  output logic                     out_bound_err,
`ifdef ODPC_PARITY_EN
  input  logic [NUM_CH-1:0]        in_par,
  output logic [NUM_CH-1:0]        out_par_err,
`endif
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         oor_count
);

  logic s1_adv, s2_adv;

  logic                     s1_valid_q;
  logic [NUM_CH*DATA_W-1:0] s1_x_q, s1_dmax_q, s1_dmin_q;
  logic [NUM_CH*DATA_W-1:0] s1_dmax_d, s1_dmin_d;
  logic [DATA_W-1:0]        s1_min_q, s1_max_q;
  logic [NUM_CH-1:0]        s1_gt_q, s1_lt_q, s1_gt_d, s1_lt_d;
  logic                     s1_berr_q;
  logic [NUM_CH-1:0]        s1_perr;

  logic                     out_valid_q;
  logic [NUM_CH*DATA_W-1:0] out_x_q, out_x_d;
  logic [NUM_CH*CODE_W-1:0] out_code_max_q, out_code_max_d;
  logic [NUM_CH*CODE_W-1:0] out_code_min_q, out_code_min_d;
  logic [NUM_CH-1:0]        out_hi_q, out_hi_d, out_lo_q, out_lo_d;
  logic                     out_bound_err_q;
  logic [CNT_W-1:0]         oor_count_q;
  logic [CNT_W:0]           cnt_sum;

  // No skid buffer: upstream sees the S1 advance condition directly.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_s1
      logic [DATA_W-1:0] x_ch;
      assign x_ch = in_x[gi*DATA_W +: DATA_W];
      assign s1_dmax_d[gi*DATA_W +: DATA_W] = x_ch ^ in_max;
      assign s1_dmin_d[gi*DATA_W +: DATA_W] = x_ch ^ in_min;
      assign s1_gt_d[gi] = x_ch > in_max;
      assign s1_lt_d[gi] = x_ch < in_min;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_dmax_q  <= '0;
      s1_dmin_q  <= '0;
      s1_min_q   <= '0;
      s1_max_q   <= '0;
      s1_gt_q    <= '0;
      s1_lt_q    <= '0;
      s1_berr_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_x_q    <= in_x;
        s1_dmax_q <= s1_dmax_d;
        s1_dmin_q <= s1_dmin_d;
        s1_min_q  <= in_min;
        s1_max_q  <= in_max;
        s1_gt_q   <= s1_gt_d;
        s1_lt_q   <= s1_lt_d;
        s1_berr_q <= in_min > in_max;
      end
    end
  end

`ifdef ODPC_PARITY_EN
  logic [NUM_CH-1:0] s1_perr_q, s1_perr_d, out_par_err_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_par
      assign s1_perr_d[gi] = (^in_x[gi*DATA_W +: DATA_W]) ^ in_par[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_perr_q     <= '0;
      out_par_err_q <= '0;
    end else begin
      if (s1_adv && in_valid) s1_perr_q <= s1_perr_d;
      if (s2_adv && s1_valid_q) out_par_err_q <= s1_perr_q;
    end
  end

  assign s1_perr     = s1_perr_q;
  assign out_par_err = out_par_err_q;
`else
  assign s1_perr = '0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_s2
      logic [DATA_W-1:0] x_ch, hi_val, lo_val;
      logic [CODE_W-1:0] cmax, cmin;
      logic              pe, hi, lo;

      assign x_ch   = s1_x_q[gi*DATA_W +: DATA_W];
      assign pe     = s1_perr[gi];
      // An inverted bound window suppresses both flags and leaves data untouched.
      assign hi     = s1_gt_q[gi] & ~s1_berr_q & ~pe;
      assign lo     = s1_lt_q[gi] & ~s1_berr_q & ~pe;
      assign hi_val = (CLAMP_MODE == CLAMP_ZERO) ? '0 : s1_max_q;
      assign lo_val = (CLAMP_MODE == CLAMP_ZERO) ? '0 : s1_min_q;

      odpc_msb_diff_encoder #(.DATA_W(DATA_W), .CODE_W(CODE_W)) u_enc_max (
        .d_i    (s1_dmax_q[gi*DATA_W +: DATA_W]),
        .code_o (cmax)
      );
      odpc_msb_diff_encoder #(.DATA_W(DATA_W), .CODE_W(CODE_W)) u_enc_min (
        .d_i    (s1_dmin_q[gi*DATA_W +: DATA_W]),
        .code_o (cmin)
      );

      assign out_x_d[gi*DATA_W +: DATA_W] = pe ? '0 : hi ? hi_val : lo ? lo_val : x_ch;
      assign out_code_max_d[gi*CODE_W +: CODE_W] = pe ? '0 : cmax;
      assign out_code_min_d[gi*CODE_W +: CODE_W] = pe ? '0 : cmin;
      assign out_hi_d[gi] = hi;
      assign out_lo_d[gi] = lo;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_x_q         <= '0;
      out_code_max_q  <= '0;
      out_code_min_q  <= '0;
      out_hi_q        <= '0;
      out_lo_q        <= '0;
      out_bound_err_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_x_q         <= out_x_d;
        out_code_max_q  <= out_code_max_d;
        out_code_min_q  <= out_code_min_d;
        out_hi_q        <= out_hi_d;
        out_lo_q        <= out_lo_d;
        out_bound_err_q <= s1_berr_q;
      end
    end
  end

  assign cnt_sum = {1'b0, oor_count_q}
                 + (CNT_W+1)'(popcount(32'(out_hi_q | out_lo_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_count_q <= '0;
    end else if (cnt_clr) begin
      oor_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      oor_count_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  assign out_valid     = out_valid_q;
  assign out_x         = out_x_q;
  assign out_code_max  = out_code_max_q;
  assign out_code_min  = out_code_min_q;
  assign out_hi        = out_hi_q;
  assign out_lo        = out_lo_q;
  assign out_bound_err = out_bound_err_q;
  assign oor_count     = oor_count_q;

endmodule

// File: tb/tb_odpc_range_guard_pipe.sv
// Scoreboard bench for odpc_range_guard_pipe: a clamp-to-bound and a force-to-zero
// instance share stimulus; expected beats are queued at acceptance.
module tb_odpc_range_guard_pipe;
  import odpc_pkg::*;

  localparam int DW = 8, NC = 4, CW = 4, CNTW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic [NC*DW-1:0] in_x = '0;
  logic [DW-1:0]    in_min = '0, in_max = '0;
  logic             in_ready, out_valid, out_bound_err;
  logic [NC*DW-1:0] out_x;
  logic [NC*CW-1:0] out_code_max, out_code_min;
  logic [NC-1:0]    out_hi, out_lo;
  logic [CNTW-1:0]  oor_count;
  logic             z_in_ready, z_out_valid, z_out_bound_err;
  logic [NC*DW-1:0] z_out_x;
  logic [NC*CW-1:0] z_out_code_max, z_out_code_min;
  logic [NC-1:0]    z_out_hi, z_out_lo;
  logic [CNTW-1:0]  z_oor_count;
`ifdef ODPC_PARITY_EN
  logic [NC-1:0]    in_par = '0;
  logic [NC-1:0]    out_par_err, z_out_par_err;
`endif

  odpc_range_guard_pipe #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CNTW), .CLAMP_MODE(CLAMP_BOUND)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_min(in_min), .in_max(in_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_code_max(out_code_max), .out_code_min(out_code_min),
    .out_hi(out_hi), .out_lo(out_lo), .out_bound_err(out_bound_err),
`ifdef ODPC_PARITY_EN
    .in_par(in_par), .out_par_err(out_par_err),
`endif
    .cnt_clr(cnt_clr), .oor_count(oor_count)
  );

  odpc_range_guard_pipe #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CNTW), .CLAMP_MODE(CLAMP_ZERO)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_x(in_x), .in_min(in_min), .in_max(in_max),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_x(z_out_x),
    .out_code_max(z_out_code_max), .out_code_min(z_out_code_min),
    .out_hi(z_out_hi), .out_lo(z_out_lo), .out_bound_err(z_out_bound_err),
`ifdef ODPC_PARITY_EN
    .in_par(in_par), .out_par_err(z_out_par_err),
`endif
    .cnt_clr(cnt_clr), .oor_count(z_oor_count)
  );

  typedef struct {
    logic [NC*DW-1:0] x, xz;
    logic [NC*CW-1:0] cmax, cmin;
    logic [NC-1:0]    hi, lo, perr;
    logic             berr;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_pass = 0, n_total = 0, accepted = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [CW-1:0] ref_code(input logic [DW-1:0] d);
    for (int b = DW - 1; b >= 0; b--) if (d[b]) return {1'b1, 3'(b)};
    return '0;
  endfunction

  function automatic exp_t model(input logic [NC*DW-1:0] x, input logic [DW-1:0] mn,
                                 input logic [DW-1:0] mx, input logic [NC-1:0] flip);
    exp_t e;
    logic [DW-1:0] xc;
    e.x = '0; e.xz = '0; e.cmax = '0; e.cmin = '0;
    e.hi = '0; e.lo = '0; e.perr = flip; e.berr = (mn > mx);
    for (int c = 0; c < NC; c++) begin
      xc = x[c*DW +: DW];
      if (!flip[c]) begin
        e.cmax[c*CW +: CW] = ref_code(xc ^ mx);
        e.cmin[c*CW +: CW] = ref_code(xc ^ mn);
        if (!e.berr && xc > mx) begin
          e.hi[c] = 1'b1; e.x[c*DW +: DW] = mx;
        end else if (!e.berr && xc < mn) begin
          e.lo[c] = 1'b1; e.x[c*DW +: DW] = mn;
        end else begin
          e.x[c*DW +: DW] = xc; e.xz[c*DW +: DW] = xc;
        end
      end
    end
    return e;
  endfunction

  task automatic send_beat(input logic [NC*DW-1:0] x, input logic [DW-1:0] mn,
                           input logic [DW-1:0] mx, input logic [NC-1:0] flip);
    logic ok;
    in_valid = 1'b1; in_x = x; in_min = mn; in_max = mx;
`ifdef ODPC_PARITY_EN
    for (int c = 0; c < NC; c++) in_par[c] = (^x[c*DW +: DW]) ^ flip[c];
`endif
    ok = 1'b0;
    for (int w = 0; w < 100 && !ok; w++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check_eq("accept", ok, 1'b1);
    if (ok) begin
      sb.push_back(model(x, mn, mx, flip));
      accepted++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    logic seen;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check_eq("out_valid_wait", seen, 1'b1);
  endtask

  task automatic drain();
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard consumer: compares every output transfer in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", out_valid, 1'b0);
      end else begin
        got = sb.pop_front();
        check_eq("out_x", out_x, got.x);
        check_eq("out_x_zero_mode", z_out_x, got.xz);
        check_eq("code_max", out_code_max, got.cmax);
        check_eq("code_min", out_code_min, got.cmin);
        check_eq("hi", out_hi, got.hi);
        check_eq("lo", out_lo, got.lo);
        check_eq("bound_err", out_bound_err, got.berr);
`ifdef ODPC_PARITY_EN
        check_eq("par_err", out_par_err, got.perr);
`endif
        $display("beat x=%h code_max=%h code_min=%h hi=%b lo=%b berr=%b",
                 out_x, out_code_max, out_code_min, out_hi, out_lo, out_bound_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [NC*DW-1:0] held;
  localparam logic [NC*DW-1:0] X_MIX = {8'h80, 8'h10, 8'h90, 8'h50};

  initial begin
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_x", out_x, '0);
    check_eq("rst_codes", {out_code_max, out_code_min}, '0);
    check_eq("rst_flags", {out_hi, out_lo, out_bound_err}, '0);
    check_eq("rst_oor_count", oor_count, '0);
    #5 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Nominal, over, under and equality on one beat, plus two-cycle latency.
    send_beat(X_MIX, 8'h20, 8'h80, '0);
    @(negedge clk);
    check_eq("latency_c1", out_valid, 1'b0);
    @(negedge clk);
    check_eq("latency_c2", out_valid, 1'b1);
    @(posedge clk); #1;
    send_beat('0, 8'h00, 8'h00, '0);
    send_beat({8'h10, 8'h90, 8'hFF, 8'h00}, 8'h90, 8'h10, '0);
    send_beat({4{8'hFF}}, 8'h00, 8'hFF, '0);
    drain();

    // Random beats under random downstream stalls.
    fork
      begin
        for (int i = 0; i < 20; i++)
          send_beat($urandom, 8'($urandom_range(0, 128)), 8'($urandom_range(64, 255)), '0);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Backpressure: four beats against a six-cycle stall.
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int b = 0; b < 4; b++) send_beat({4{8'(8'h30 + 8'(b * 40))}}, 8'h40, 8'hA0, '0);
      end
      begin
        repeat (3) @(negedge clk);
        held = out_x;
        repeat (3) begin
          @(negedge clk);
          check_eq("bp_hold", out_x, held);
        end
        check_eq("bp_accepted", 64'(accepted), 64'd2);
        check_eq("bp_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter: saturation, clear priority, plain count.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check_eq("cnt_cleared", oor_count, '0);
    @(posedge clk); #1;
    for (int b = 0; b < 5; b++) send_beat({4{8'hFF}}, 8'h00, 8'h80, '0);
    drain();
    check_eq("cnt_saturated", oor_count, 4'hF);
    out_ready = 1'b0;
    send_beat({4{8'hFF}}, 8'h00, 8'h80, '0);
    wait_out_valid();
    @(posedge clk); #1;
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check_eq("cnt_clr_priority", oor_count, '0);
    @(posedge clk); #1;
    send_beat({8'hFF, 8'h00, 8'h50, 8'h50}, 8'h20, 8'h80, '0);
    drain();
    check_eq("cnt_two", oor_count, 4'h2);

    // Asynchronous reset while a beat is presented.
    out_ready = 1'b0;
    send_beat(X_MIX, 8'h20, 8'h80, '0);
    wait_out_valid();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_out_valid", out_valid, 1'b0);
    check_eq("async_oor_count", oor_count, '0);
    check_eq("async_out_x", out_x, '0);
    sb.delete();
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_beat(X_MIX, 8'h20, 8'h80, '0);
    @(negedge clk);
    check_eq("post_rst_c1", out_valid, 1'b0);
    @(negedge clk);
    check_eq("post_rst_c2", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();

`ifdef ODPC_PARITY_EN
    send_beat(X_MIX, 8'h20, 8'h80, 4'b0100);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/odpc_range_guard_pipe.md
Name: odpc_range_guard_pipe

Overview:
- Multi-channel, pipelined successor to the single-lane ODPC data processing path.
- Each channel compares a data word against shared min/max bounds and emits bit-difference codes for both bounds.
- Out-of-range words are clamped or zeroed; hi/lo fault flags are raised.
- Sits between the PE-array output and the activation write-back in the fault-tolerant CNN accelerator, under a valid/ready handshake.

Parameters:
- DATA_W, 8: width of each data word and bound, unsigned.
- NUM_CH, 4: number of parallel channels per beat.
- CODE_W, $clog2(DATA_W)+1: width of each encoded comparison code.
- CNT_W, 16: width of the out-of-range event counter.
- CLAMP_MODE, 0: out-of-range handling. 0 = clamp to the violated bound. 1 = force to zero.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_x  in  NUM_CH*DATA_W  channel data; channel 0 in the LSBs
- in_min  in  DATA_W  lower bound, sampled with the beat
- in_max  in  DATA_W  upper bound, sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_x  out  NUM_CH*DATA_W  guarded data
- out_code_max  out  NUM_CH*CODE_W  per-channel code of x versus max
- out_code_min  out  NUM_CH*CODE_W  per-channel code of x versus min
- out_hi  out  NUM_CH  x > max
- out_lo  out  NUM_CH  x < min
- out_bound_err  out  1  min > max for this beat
- cnt_clr  in  1  synchronous clear of oor_count
- oor_count  out  CNT_W  saturating count of out-of-range channel events

Behaviour:
- Reset: every register clears while rst_n is low, regardless of clk. out_valid=0, all data/code/flag outputs=0, oor_count=0, stage valids=0. in_ready=1 from the first cycle after reset release.
- Pipeline, 2 stages:
  - S1 registers inputs, per-channel diff vectors d_max=x^max and d_min=x^min, and unsigned compares.
  - S2 registers the encoded codes, flags and guarded data.
- Latency is 2 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- Handshake:
  - A stage advances when it is empty or the stage after it advances; S2 advances when !out_valid || out_ready.
  - in_ready = S1 advance condition, computed combinationally; there is no skid buffer.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - No beat is lost or duplicated; order is preserved.
- Code: {found, idx}. found=1 iff d≠0; idx = bit index of the most significant set bit of d, counted from the MSB as DATA_W-1. d=0 gives code all-zero.
- Flags, unsigned compare:
  - x==max gives hi=0; x==min gives lo=0.
  - hi and lo are never both 1 unless bound_err.
- Guarded data:
  - hi: max (CLAMP_MODE 0) or 0 (CLAMP_MODE 1).
  - lo: min (CLAMP_MODE 0) or 0 (CLAMP_MODE 1).
  - otherwise x.
- Bound error: if min>max, out_bound_err=1, data passes unchanged, hi/lo forced to 0, codes still generated.
- Counter:
  - On each S2 output transfer (out_valid && out_ready), add popcount(out_hi|out_lo), saturating at all-ones.
  - cnt_clr has priority over a same-cycle increment: the result is 0.
- Reset mid-operation: in-flight beats are discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: ODPC_PARITY_EN.
- When defined:
  - Adds input in_par (NUM_CH bits, even parity per channel word) and output out_par_err (NUM_CH bits).
  - On mismatch, that channel's out_x=0, its codes=0, its flags=0, out_par_err bit=1. The channel is not counted in oor_count.
- When undefined: the ports are absent and there is no parity logic.

Decomposition:
- Package odpc_pkg holds:
  - function code_w(data_w).
  - CLAMP_MODE localparams CLAMP_BOUND=0, CLAMP_ZERO=1.
  - a popcount function.
- Sub-module odpc_msb_diff_encoder (param DATA_W): combinational diff vector to {found, idx}. It is instantiated 2*NUM_CH times in S2.

Test Plan (DATA_W=8, NUM_CH=4):
- Nominal: x=0x50, min=0x20, max=0x80, out_ready=1 → 2 cycles later out_x=0x50, code_max=4'hF, code_min=4'hE, hi=lo=0.
- Over/under range, CLAMP_MODE 0: x=0x90 → out_x=0x80, hi=1, code_max=4'hC. x=0x10 → out_x=0x20, lo=1. With CLAMP_MODE 1, both → out_x=0x00.
- Equality and bound error: x=max=0x80 → code_max=4'h0, hi=0. min=0x90, max=0x10 → bound_err=1, out_x=x, flags 0.
- Backpressure: send 4 beats with out_ready=0 for 6 cycles → in_ready=0 after 2 beats accepted; out_x held stable; all 4 beats appear in order once ready, none dropped.
- Counter: CNT_W=4, 5 beats each with 4 channels out of range → oor_count=4'hF saturated. cnt_clr asserted in the same cycle as an event → oor_count=0.
- Reset mid-stream: drop rst_n while out_valid=1 → out_valid=0 and oor_count=0 immediately. After release, the first new beat emerges after 2 cycles. With ODPC_PARITY_EN, a flipped bit on ch2 → out_par_err=4'b0100 and ch2 out_x=0.
